// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the fetch/load-store stages, the shared memory and imem_dmem_arbiter.
// The arbiter uses the slave view; the environment (stages plus memory) uses the master view.
interface imem_dmem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_kill;
  logic [31:0] i_rdata;
  logic        i_ack;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  logic        fetch_stall;
  logic        mem_stall;

  modport master (
    output i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, fetch_stall, mem_stall
  );

  modport slave (
    input  i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, fetch_stall, mem_stall
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and load/store, one txn at a time.
// Data has priority; a starvation counter forces an instruction grant after STARVE_LIMIT wins.
module imem_dmem_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  imem_dmem_arbiter_if.slave bus
);

  localparam int unsigned CntW    = $clog2(MEM_LATENCY + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0]    CntInit   = CntW'(MEM_LATENCY);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                owner_instr_q, owner_instr_d;
  logic                kill_q, kill_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [31:0]         m_addr_q, m_addr_d;
  logic [31:0]         m_wdata_q, m_wdata_d;
  logic [31:0]         ibuf_q, ibuf_d;
  logic [31:0]         i_rdata_q, i_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;

  logic grant_instr;
  logic instr_done;
  logic data_done;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

  assign grant_instr = bus.i_req && (!bus.d_req || (starve_q == StarveMax));

  // A kill arriving in the DONE cycle itself must still swallow the ack.
  assign instr_done = (state_q == StDone) && owner_instr_q && !kill_q && !bus.i_kill;
  assign data_done  = (state_q == StDone) && !owner_instr_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    starve_d      = starve_q;
    owner_instr_d = owner_instr_q;
    kill_d        = kill_q;
    m_req_d       = 1'b0;
    m_we_d        = m_we_q;
    m_addr_d      = m_addr_q;
    m_wdata_d     = m_wdata_q;
    ibuf_d        = ibuf_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.i_req || bus.d_req) begin
          owner_instr_d = grant_instr;
          kill_d        = 1'b0;
          m_req_d       = 1'b1;
          m_we_d        = grant_instr ? 1'b0 : bus.d_we;
          m_addr_d      = grant_instr ? {bus.i_addr[31:2], 2'b00} : {bus.d_addr[31:2], 2'b00};
          m_wdata_d     = bus.d_wdata;
          cnt_d         = CntInit;
          state_d       = StWait;
          if (grant_instr || !bus.i_req) begin
            starve_d = '0;
          end else if (starve_q != StarveMax) begin
            starve_d = starve_q + StarveW'(1);
          end
        end
      end

      StWait: begin
        if (owner_instr_q && bus.i_kill) begin
          kill_d = 1'b1;
        end
        if (cnt_q == '0) begin
          // Instruction data is staged so a late kill can still keep i_rdata untouched.
          if (owner_instr_q) begin
            ibuf_d = bus.m_rdata;
          end else if (!m_we_q) begin
            d_rdata_d = bus.m_rdata;
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StDone: begin
        if (instr_done) begin
          i_rdata_d = ibuf_q;
        end
        kill_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      starve_q      <= '0;
      owner_instr_q <= 1'b0;
      kill_q        <= 1'b0;
      m_req_q       <= 1'b0;
      m_we_q        <= 1'b0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      ibuf_q        <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      starve_q      <= starve_d;
      owner_instr_q <= owner_instr_d;
      kill_q        <= kill_d;
      m_req_q       <= m_req_d;
      m_we_q        <= m_we_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      ibuf_q        <= ibuf_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
    end
  end

  assign bus.m_req       = m_req_q;
  assign bus.m_we        = m_we_q;
  assign bus.m_addr      = m_addr_q;
  assign bus.m_wdata     = m_wdata_q;
  assign bus.i_ack       = instr_done;
  assign bus.d_ack       = data_done;
  assign bus.i_rdata     = instr_done ? ibuf_q : i_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.fetch_stall = bus.i_req && !instr_done;
  assign bus.mem_stall   = bus.d_req && !data_done;

endmodule
